program_loader: RTL

- Hardware boot loader that fills the pipelined CPU's instruction memory from a byte stream, then releases the CPU by asserting its start input.
- Replaces the bench-side backdoor load of instruction memory with a real load path; it is the write-side counterpart of the state dump read out at the bench.
- Sits between an external byte source (UART receiver or bench driver) and the instruction-memory write port. `start_o` connects to the CPU's `start_i`.

---
 rtl/program_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: byte stream -> instruction memory writes, then raises start_o.
// Optional trailing XOR checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int IMEM_WORDS = 256,
    parameter int CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    output logic             byte_ready_o,
    output logic             imem_we_o,
    output logic [31:0]      imem_addr_o,
    output logic [31:0]      imem_data_o,
    output logic             start_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [CNT_W-1:0] words_loaded_o
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q;
    logic             live_q;
    logic [1:0]       bi_q;
    logic [31:0]      n_q;
    logic [31:0]      wd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [31:0]      data_q;
    logic             start_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]       csum_q;
`endif

    logic [31:0]      n_d;
    logic [31:0]      wd_d;
    logic [CNT_W-1:0] cnt_d;
    logic             drain;
    logic             take;

    assign n_d   = {byte_i, n_q[31:8]};
    assign wd_d  = {byte_i, wd_q[31:8]};
    assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // After the last word is written, one cycle is spent in LOAD with
    // ready low so start_o follows the final write pulse.
    assign drain = (state_q == S_LOAD) && (32'(cnt_q) == n_q);

    assign busy_o = live_q && (state_q == S_HDR || state_q == S_LOAD ||
                               state_q == S_CHK);
    assign byte_ready_o   = busy_o && !drain;
    assign take           = byte_valid_i && byte_ready_o;
    assign error_o        = (state_q == S_ERR);
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_data_o    = data_q;
    assign start_o        = start_q;
    assign words_loaded_o = cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_HDR;
            live_q  <= 1'b0;
            bi_q    <= 2'd0;
            n_q     <= 32'd0;
            wd_q    <= 32'd0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            start_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            live_q <= 1'b1;
            we_q   <= 1'b0;
            unique case (state_q)
                S_HDR: begin
                    if (take) begin
                        n_q  <= n_d;
                        bi_q <= bi_q + 2'd1;
                        if (bi_q == 2'd3) begin
                            cnt_q <= '0;
                            if (n_d == 32'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
                                start_q <= 1'b1;
`endif
                            end else if (n_d > 32'(IMEM_WORDS)) begin
                                state_q <= S_ERR;
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (drain) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        state_q <= S_CHK;
`else
                        state_q <= S_DONE;
                        start_q <= 1'b1;
`endif
                    end else if (take) begin
                        wd_q <= wd_d;
                        bi_q <= bi_q + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ byte_i;
`endif
                        if (bi_q == 2'd3) begin
                            we_q   <= 1'b1;
                            data_q <= wd_d;
                            addr_q <= 32'(cnt_q) << 2;
                            cnt_q  <= cnt_d;
                        end
                    end
                end
                S_CHK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                    if (take) begin
                        if (byte_i == csum_q) begin
                            state_q <= S_DONE;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= S_ERR;
                        end
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
